// File: rtl/mem_wb_buf.sv
// MEM/WB write-back buffer: a small circular queue of pending register writes
// that drains one entry per cycle into registered write-back outputs and forwards to decode.
module mem_wb_buf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ADDR_W-1:0]         in_addr,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      wb_flag,
    output logic [ADDR_W-1:0]         wb_address,
    output logic [DATA_W-1:0]         wb_data,
    input  logic [ADDR_W-1:0]         fwd_addr,
    output logic                      fwd_hit,
    output logic [DATA_W-1:0]         fwd_data,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic              r_wb_flag;
    logic [ADDR_W-1:0] r_wb_address;
    logic [DATA_W-1:0] r_wb_data;

    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_hit;
    logic [DATA_W-1:0] w_fwd_data;

    // Ready depends only on registered occupancy, so a same-cycle pop never frees a full slot.
    assign w_ready = rst && !flush && (r_count < CNT_W'(DEPTH));
    // Writes to register 0 complete the handshake but are never queued.
    assign w_push  = in_valid && w_ready && (in_addr != '0);
    assign w_pop   = !stall && !flush && (r_count != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_wb_flag    <= 1'b0;
            r_wb_address <= '0;
            r_wb_data    <= '0;
        end else if (flush) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_wb_flag    <= 1'b0;
            r_wb_address <= '0;
            r_wb_data    <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head       <= r_head + 1'b1;
                r_wb_flag    <= 1'b1;
                r_wb_address <= r_mem_addr[r_head];
                r_wb_data    <= r_mem_data[r_head];
            end else begin
                r_wb_flag    <= 1'b0;
                r_wb_address <= '0;
                r_wb_data    <= '0;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage needs no reset; only entries between head and tail are ever read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_tail] <= in_addr;
            r_mem_data[r_tail] <= in_data;
        end
    end

    // Walk oldest to youngest so the youngest match overrides; wb register is lowest priority.
    always_comb begin
        logic [PTR_W-1:0] idx;
        w_hit      = 1'b0;
        w_fwd_data = '0;
        idx        = '0;
        if (r_wb_flag && (r_wb_address == fwd_addr)) begin
            w_hit      = 1'b1;
            w_fwd_data = r_wb_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = r_head + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_mem_addr[idx] == fwd_addr)) begin
                w_hit      = 1'b1;
                w_fwd_data = r_mem_data[idx];
            end
        end
        if (fwd_addr == '0) begin
            w_hit      = 1'b0;
            w_fwd_data = '0;
        end
    end

    assign in_ready   = w_ready;
    assign wb_flag    = r_wb_flag;
    assign wb_address = r_wb_address;
    assign wb_data    = r_wb_data;
    assign fwd_hit    = w_hit;
    assign fwd_data   = w_fwd_data;
    assign count      = r_count;

endmodule

// File: tb/tb_mem_wb_buf.sv
// Scoreboard bench for mem_wb_buf: a queue-based reference model predicts write-backs,
// occupancy, ready and forwarding; a negedge monitor compares the registered outputs.
module tb_mem_wb_buf;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              wb_flag;
    logic [ADDR_W-1:0] wb_address;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] fwd_addr = '0;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [CNT_W-1:0]  count;

    always #5 clk = ~clk;

    mem_wb_buf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
        .wb_flag(wb_flag), .wb_address(wb_address), .wb_data(wb_data),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
    );

    ent_t mq[$];
    ent_t exp_q[$];
    bit   exp_flag  = 1'b0;
    int   exp_count = 0;
    bit   last_flag = 1'b0;
    ent_t last_wb;
    bit   mon_en    = 1'b0;
    int   vectors   = 0;
    int   errors    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle: drive inputs, check combinational outputs, advance the reference model.
    task automatic step(input bit r, input bit s, input bit f, input bit v,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [ADDR_W-1:0] fa);
        ent_t e;
        ent_t n;
        bit   pop;
        bit   push;
        bit   m_hit;
        logic [DATA_W-1:0] m_data;
        @(negedge clk);
        #2;
        rst = r; stall = s; flush = f; in_valid = v; in_addr = a; in_data = d; fwd_addr = fa;
        #1;
        m_hit  = 1'b0;
        m_data = '0;
        if (last_flag && last_wb.a == fa) begin
            m_hit  = 1'b1;
            m_data = last_wb.d;
        end
        foreach (mq[i]) begin
            if (mq[i].a == fa) begin
                m_hit  = 1'b1;
                m_data = mq[i].d;
            end
        end
        if (fa == '0) begin
            m_hit  = 1'b0;
            m_data = '0;
        end
        chk("in_ready", in_ready, r && !f && (mq.size() < DEPTH));
        if (mon_en) begin
            chk("fwd_hit", fwd_hit, m_hit);
            chk("fwd_data", fwd_data, m_data);
        end
        if (!r || f) begin
            mq.delete();
            exp_flag = 1'b0;
        end else begin
            pop      = !s && (mq.size() > 0);
            push     = v && (mq.size() < DEPTH) && (a != '0);
            exp_flag = 1'b0;
            if (pop) begin
                e = mq.pop_front();
                exp_q.push_back(e);
                exp_flag = 1'b1;
                last_wb  = e;
            end
            if (push) begin
                n.a = a;
                n.d = d;
                mq.push_back(n);
            end
        end
        last_flag = exp_flag;
        exp_count = mq.size();
        mon_en    = 1'b1;
    endtask

    task automatic idle(input logic [ADDR_W-1:0] fa);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, fa);
    endtask

    initial begin : monitor
        ent_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("wb_flag", wb_flag, exp_flag);
                chk("count", count, exp_count);
                if (wb_flag) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL wb_unexpected: got addr %0h data %0h expected no write-back",
                                 wb_address, wb_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wb_address", wb_address, e.a);
                        chk("wb_data", wb_data, e.d);
                    end
                end else begin
                    chk("wb_address_idle", wb_address, '0);
                    chk("wb_data_idle", wb_data, '0);
                end
            end
        end
    end

    initial begin : driver
        step(0, 0, 0, 0, '0, '0, '0);
        step(0, 0, 0, 1, 5'd7, 32'h77, '0);

        // Single entry into an empty buffer, then idle.
        step(1, 0, 0, 1, 5'd3, 32'h11, 5'd3);
        idle(5'd3);
        idle(5'd3);

        // Fill under stall, attempt a push while full, then drain in order.
        for (int i = 1; i <= 4; i++) step(1, 1, 0, 1, 5'(i), 32'h100 + 32'(i), 5'd2);
        step(1, 1, 0, 1, 5'd9, 32'h99, 5'd4);
        for (int i = 0; i < 5; i++) idle(5'd4);

        // Two writes to the same register: the younger must forward.
        step(1, 1, 0, 1, 5'd5, 32'hA, 5'd5);
        step(1, 1, 0, 1, 5'd5, 32'hB, 5'd5);
        step(1, 1, 0, 0, '0, '0, 5'd5);
        step(1, 1, 0, 0, '0, '0, '0);

        // Flush with three entries queued and a concurrent push.
        step(1, 1, 0, 1, 5'd6, 32'h66, 5'd6);
        step(1, 1, 1, 1, 5'd7, 32'h77, 5'd7);
        idle(5'd7);
        idle(5'd5);

        // Register-0 write is accepted but dropped; reset in the middle of a drain.
        step(1, 0, 0, 1, '0, 32'hDEAD, '0);
        idle('0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 5'(10 + i), 32'h200 + 32'(i), 5'd11);
        idle(5'd10);
        step(0, 0, 0, 1, 5'd13, 32'h13, 5'd11);
        idle(5'd11);
        idle(5'd12);

        // Full queue under continuous traffic: pointers wrap.
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 5'(20 + i), $urandom, 5'd21);
        for (int i = 0; i < 20; i++)
            step(1, 0, 0, 1, 5'($urandom_range(1, 31)), $urandom, 5'($urandom_range(0, 31)));

        // Random traffic with a narrow address range to exercise forwarding priority.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) >= 2, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 70,
                 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)));

        for (int i = 0; i < 8; i++) idle('0);
        @(negedge clk);
        #1;
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
